frontend_pipe_regs: RTL and testbench

Fetch/decode/execute pipeline register bank for the RV32I five-stage core. It consumes the hazard controls `stallF`, `stallD`, `flushD` and `flushE`, and applies them to three registers: the PC register, the IF/ID register and the ID/EX register. It tracks a per-stage valid bit so that bubbles are visible downstream. It also keeps three wrapping performance counters for stall and flush activity.

---
 rtl/frontend_pipe_regs.sv | 115 +++++++++++
 tb/tb_frontend_pipe_regs.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/frontend_pipe_regs.sv
// PC, IF/ID and ID/EX pipeline registers for the RV32I five-stage core,
// with per-stage valid bits and wrapping stall/flush activity counters.
module frontend_pipe_regs #(
    parameter int XLEN = 32,
    parameter int CTRL_W = 16,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stallF,
    input  logic              stallD,
    input  logic              flushD,
    input  logic              flushE,
    input  logic              perf_clr,
    input  logic [XLEN-1:0]   pcnextF,
    input  logic [31:0]       instrF,
    input  logic [XLEN-1:0]   pcplus4F,
    output logic [XLEN-1:0]   pcF,
    output logic [31:0]       instrD,
    output logic [XLEN-1:0]   pcD,
    output logic [XLEN-1:0]   pcplus4D,
    output logic              validD,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic [XLEN-1:0]   rd1D,
    input  logic [XLEN-1:0]   rd2D,
    input  logic [XLEN-1:0]   immextD,
    input  logic [4:0]        rs1D,
    input  logic [4:0]        rs2D,
    input  logic [4:0]        rdD,
    output logic [CTRL_W-1:0] ctrlE,
    output logic [XLEN-1:0]   rd1E,
    output logic [XLEN-1:0]   rd2E,
    output logic [XLEN-1:0]   immextE,
    output logic [XLEN-1:0]   pcE,
    output logic [XLEN-1:0]   pcplus4E,
    output logic [4:0]        rs1E,
    output logic [4:0]        rs2E,
    output logic [4:0]        rdE,
    output logic              validE,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flushd_cnt,
    output logic [31:0]       flushe_cnt
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcF <= RESET_PC;
        end else if (!stallF) begin
            pcF <= pcnextF;
        end
    end

    // Flush beats stall here so a taken branch squashes a held instruction.
    always_ff @(posedge clk) begin
        if (!reset_n || flushD) begin
            instrD   <= '0;
            pcD      <= '0;
            pcplus4D <= '0;
            validD   <= 1'b0;
        end else if (!stallD) begin
            instrD   <= instrF;
            pcD      <= pcF;
            pcplus4D <= pcplus4F;
            validD   <= 1'b1;
        end
    end

    // A flushed slot clears the register indices too, so a bubble can never
    // match a forwarding or load-use comparison.
    always_ff @(posedge clk) begin
        if (!reset_n || flushE) begin
            ctrlE    <= '0;
            rd1E     <= '0;
            rd2E     <= '0;
            immextE  <= '0;
            pcE      <= '0;
            pcplus4E <= '0;
            rs1E     <= '0;
            rs2E     <= '0;
            rdE      <= '0;
            validE   <= 1'b0;
        end else begin
            ctrlE    <= ctrlD;
            rd1E     <= rd1D;
            rd2E     <= rd2D;
            immextE  <= immextD;
            pcE      <= pcD;
            pcplus4E <= pcplus4D;
            rs1E     <= rs1D;
            rs2E     <= rs2D;
            rdE      <= rdD;
            validE   <= validD;
        end
    end

    // A stall that coincides with a D flush is not counted as a stall.
    always_ff @(posedge clk) begin
        if (!reset_n || perf_clr) begin
            stall_cnt  <= '0;
            flushd_cnt <= '0;
            flushe_cnt <= '0;
        end else begin
            if (stallD && !flushD) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flushD) begin
                flushd_cnt <= flushd_cnt + 32'd1;
            end
            if (flushE) begin
                flushe_cnt <= flushe_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_frontend_pipe_regs.sv
// Directed, table-driven bench for frontend_pipe_regs: free run, load-use,
// taken branch, flush/stall priority, counter clear/wrap and reset mid-stall.
module tb_frontend_pipe_regs;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stallF, stallD, flushD, flushE, perf_clr;
    logic [31:0] pcnextF, instrF, pcplus4F;
    logic [31:0] pcF, instrD, pcD, pcplus4D;
    logic        validD, validE;
    logic [15:0] ctrlD, ctrlE;
    logic [31:0] rd1D, rd2D, immextD;
    logic [4:0]  rs1D, rs2D, rdD;
    logic [31:0] rd1E, rd2E, immextE, pcE, pcplus4E;
    logic [4:0]  rs1E, rs2E, rdE;
    logic [31:0] stall_cnt, flushd_cnt, flushe_cnt;

    int checks = 0;
    int failures = 0;

    frontend_pipe_regs #(.XLEN(32), .CTRL_W(16), .RESET_PC(32'h100)) dut (
        .clk(clk), .reset_n(reset_n),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .perf_clr(perf_clr),
        .pcnextF(pcnextF), .instrF(instrF), .pcplus4F(pcplus4F),
        .pcF(pcF), .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D),
        .validD(validD),
        .ctrlD(ctrlD), .rd1D(rd1D), .rd2D(rd2D), .immextD(immextD),
        .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
        .ctrlE(ctrlE), .rd1E(rd1E), .rd2E(rd2E), .immextE(immextE),
        .pcE(pcE), .pcplus4E(pcplus4E), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .validE(validE),
        .stall_cnt(stall_cnt), .flushd_cnt(flushd_cnt), .flushe_cnt(flushe_cnt)
    );

    always #5 clk = ~clk;

    // ctl = {stallF, stallD, flushD, flushE, perf_clr}
    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] pcnext;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic [15:0] ctrl;
        logic [4:0]  rd;
        logic [31:0] expPcF;
        logic [31:0] expInstrD;
        logic [31:0] expPcD;
        logic        expValidD;
        logic        expValidE;
        logic [15:0] expCtrlE;
        logic [4:0]  expRdE;
        logic [31:0] expPcE;
        logic [31:0] expStall;
        logic [31:0] expFlushD;
        logic [31:0] expFlushE;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] ctl, input logic [31:0] pcnext, input logic [31:0] instr,
                                 input logic [31:0] pcp4, input logic [15:0] ctrl, input logic [4:0] rd);
        {stallF, stallD, flushD, flushE, perf_clr} = ctl;
        pcnextF  = pcnext;
        instrF   = instr;
        pcplus4F = pcp4;
        ctrlD    = ctrl;
        rdD      = rd;
        rs1D     = rd + 5'd1;
        rs2D     = rd + 5'd2;
        rd1D     = 32'h1000_0000 + {16'h0, ctrl};
        rd2D     = ~(32'h1000_0000 + {16'h0, ctrl});
        immextD  = {ctrl, 16'h0};
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{5'b00000, 32'h104, 32'hA000_0100, 32'h104, 16'h0011, 5'd1,  32'h104, 32'hA000_0100, 32'h100, 1'b1, 1'b0, 16'h0011, 5'd1,  32'h000, 32'd0, 32'd0, 32'd0};
        vecs[1]  = '{5'b00000, 32'h108, 32'hA000_0104, 32'h108, 16'h0022, 5'd2,  32'h108, 32'hA000_0104, 32'h104, 1'b1, 1'b1, 16'h0022, 5'd2,  32'h100, 32'd0, 32'd0, 32'd0};
        vecs[2]  = '{5'b00000, 32'h10C, 32'hA000_0108, 32'h10C, 16'h0033, 5'd3,  32'h10C, 32'hA000_0108, 32'h108, 1'b1, 1'b1, 16'h0033, 5'd3,  32'h104, 32'd0, 32'd0, 32'd0};
        vecs[3]  = '{5'b00000, 32'h110, 32'hA000_010C, 32'h110, 16'h0044, 5'd4,  32'h110, 32'hA000_010C, 32'h10C, 1'b1, 1'b1, 16'h0044, 5'd4,  32'h108, 32'd0, 32'd0, 32'd0};
        vecs[4]  = '{5'b00000, 32'h114, 32'h0020_8133, 32'h114, 16'h0055, 5'd5,  32'h114, 32'h0020_8133, 32'h110, 1'b1, 1'b1, 16'h0055, 5'd5,  32'h10C, 32'd0, 32'd0, 32'd0};
        vecs[5]  = '{5'b11010, 32'h118, 32'hA000_0114, 32'h118, 16'h0066, 5'd6,  32'h114, 32'h0020_8133, 32'h110, 1'b1, 1'b0, 16'h0000, 5'd0,  32'h000, 32'd1, 32'd0, 32'd1};
        vecs[6]  = '{5'b00000, 32'h118, 32'hA000_0114, 32'h118, 16'h0066, 5'd6,  32'h118, 32'hA000_0114, 32'h114, 1'b1, 1'b1, 16'h0066, 5'd6,  32'h110, 32'd1, 32'd0, 32'd1};
        vecs[7]  = '{5'b00110, 32'h200, 32'hA000_0118, 32'h11C, 16'h0077, 5'd7,  32'h200, 32'h0000_0000, 32'h000, 1'b0, 1'b0, 16'h0000, 5'd0,  32'h000, 32'd1, 32'd1, 32'd2};
        vecs[8]  = '{5'b00000, 32'h204, 32'hA000_0200, 32'h204, 16'h0000, 5'd0,  32'h204, 32'hA000_0200, 32'h200, 1'b1, 1'b0, 16'h0000, 5'd0,  32'h000, 32'd1, 32'd1, 32'd2};
        vecs[9]  = '{5'b00000, 32'h208, 32'hA000_0204, 32'h208, 16'h0088, 5'd8,  32'h208, 32'hA000_0204, 32'h204, 1'b1, 1'b1, 16'h0088, 5'd8,  32'h200, 32'd1, 32'd1, 32'd2};
        vecs[10] = '{5'b01100, 32'h20C, 32'hA000_0208, 32'h20C, 16'h0099, 5'd9,  32'h20C, 32'h0000_0000, 32'h000, 1'b0, 1'b1, 16'h0099, 5'd9,  32'h204, 32'd1, 32'd2, 32'd2};
        vecs[11] = '{5'b11110, 32'h300, 32'hA000_020C, 32'h210, 16'h00AA, 5'd10, 32'h20C, 32'h0000_0000, 32'h000, 1'b0, 1'b0, 16'h0000, 5'd0,  32'h000, 32'd1, 32'd3, 32'd3};
        vecs[12] = '{5'b11001, 32'h300, 32'hA000_020C, 32'h210, 16'h00BB, 5'd11, 32'h20C, 32'h0000_0000, 32'h000, 1'b0, 1'b0, 16'h00BB, 5'd11, 32'h000, 32'd0, 32'd0, 32'd0};
        vecs[13] = '{5'b00000, 32'h210, 32'hA000_020C, 32'h210, 16'h00CC, 5'd12, 32'h210, 32'hA000_020C, 32'h20C, 1'b1, 1'b0, 16'h00CC, 5'd12, 32'h000, 32'd0, 32'd0, 32'd0};
        vecs[14] = '{5'b11000, 32'h214, 32'hA000_0210, 32'h214, 16'h00DD, 5'd13, 32'h210, 32'hA000_020C, 32'h20C, 1'b1, 1'b1, 16'h00DD, 5'd13, 32'h20C, 32'd1, 32'd0, 32'd0};

        reset_n = 1'b0;
        applyStimulus(5'b00000, 32'h104, 32'hA000_0100, 32'h104, 16'h0011, 5'd1);
        repeat (3) stepClock();
        checkOutput("rst_pcF", pcF, 32'h100);
        checkOutput("rst_instrD", instrD, 32'h0);
        checkOutput("rst_pcD", pcD, 32'h0);
        checkOutput("rst_validD", {31'h0, validD}, 32'h0);
        checkOutput("rst_validE", {31'h0, validE}, 32'h0);
        checkOutput("rst_ctrlE", {16'h0, ctrlE}, 32'h0);
        checkOutput("rst_rdE", {27'h0, rdE}, 32'h0);
        checkOutput("rst_pcE", pcE, 32'h0);
        checkOutput("rst_stall", stall_cnt, 32'h0);
        checkOutput("rst_flushd", flushd_cnt, 32'h0);
        checkOutput("rst_flushe", flushe_cnt, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            logic fe;
            fe = vecs[i].ctl[1];
            applyStimulus(vecs[i].ctl, vecs[i].pcnext, vecs[i].instr, vecs[i].pcp4, vecs[i].ctrl, vecs[i].rd);
            stepClock();
            checkOutput($sformatf("r%0d_pcF", i), pcF, vecs[i].expPcF);
            checkOutput($sformatf("r%0d_instrD", i), instrD, vecs[i].expInstrD);
            checkOutput($sformatf("r%0d_pcD", i), pcD, vecs[i].expPcD);
            checkOutput($sformatf("r%0d_pcplus4D", i), pcplus4D, (vecs[i].expPcD == 0) ? 32'h0 : vecs[i].expPcD + 32'd4);
            checkOutput($sformatf("r%0d_validD", i), {31'h0, validD}, {31'h0, vecs[i].expValidD});
            checkOutput($sformatf("r%0d_validE", i), {31'h0, validE}, {31'h0, vecs[i].expValidE});
            checkOutput($sformatf("r%0d_ctrlE", i), {16'h0, ctrlE}, {16'h0, vecs[i].expCtrlE});
            checkOutput($sformatf("r%0d_rdE", i), {27'h0, rdE}, {27'h0, vecs[i].expRdE});
            checkOutput($sformatf("r%0d_rs1E", i), {27'h0, rs1E}, fe ? 32'h0 : {27'h0, vecs[i].rd + 5'd1});
            checkOutput($sformatf("r%0d_rs2E", i), {27'h0, rs2E}, fe ? 32'h0 : {27'h0, vecs[i].rd + 5'd2});
            checkOutput($sformatf("r%0d_rd1E", i), rd1E, fe ? 32'h0 : 32'h1000_0000 + {16'h0, vecs[i].ctrl});
            checkOutput($sformatf("r%0d_rd2E", i), rd2E, fe ? 32'h0 : ~(32'h1000_0000 + {16'h0, vecs[i].ctrl}));
            checkOutput($sformatf("r%0d_immextE", i), immextE, fe ? 32'h0 : {vecs[i].ctrl, 16'h0});
            checkOutput($sformatf("r%0d_pcE", i), pcE, vecs[i].expPcE);
            checkOutput($sformatf("r%0d_pcplus4E", i), pcplus4E, (vecs[i].expPcE == 0) ? 32'h0 : vecs[i].expPcE + 32'd4);
            checkOutput($sformatf("r%0d_stall", i), stall_cnt, vecs[i].expStall);
            checkOutput($sformatf("r%0d_flushd", i), flushd_cnt, vecs[i].expFlushD);
            checkOutput($sformatf("r%0d_flushe", i), flushe_cnt, vecs[i].expFlushE);
        end

        // Wrap: preload the stall counter to all-ones, then stall once more.
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        checkOutput("wrap_preload", stall_cnt, 32'hFFFF_FFFF);
        applyStimulus(5'b11000, 32'h214, 32'hA000_0210, 32'h214, 16'h00DD, 5'd13);
        stepClock();
        checkOutput("wrap_stall", stall_cnt, 32'h0);
        checkOutput("wrap_flushd", flushd_cnt, 32'h0);
        stepClock();
        checkOutput("wrap_next", stall_cnt, 32'h1);

        // Reset asserted in the middle of a load-use stall with flushes active.
        applyStimulus(5'b11110, 32'h400, 32'hA000_0400, 32'h404, 16'h00EE, 5'd14);
        reset_n = 1'b0;
        stepClock();
        checkOutput("rstmid_pcF", pcF, 32'h100);
        checkOutput("rstmid_instrD", instrD, 32'h0);
        checkOutput("rstmid_validD", {31'h0, validD}, 32'h0);
        checkOutput("rstmid_validE", {31'h0, validE}, 32'h0);
        checkOutput("rstmid_ctrlE", {16'h0, ctrlE}, 32'h0);
        checkOutput("rstmid_stall", stall_cnt, 32'h0);
        checkOutput("rstmid_flushd", flushd_cnt, 32'h0);
        checkOutput("rstmid_flushe", flushe_cnt, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
